ntt_stage_scheduler: RTL and testbench
======================================

// Module: ntt_stage_scheduler
// PURPOSE
//  Sequences one ntt_butterfly_2stage instance over an N-point coefficient RAM: in-place radix-2 NTT/iNTT.
//  Per butterfly: issues dual-port read addresses and the twiddle ROM address.
//  Write-back addresses are delayed to line up with RAM read latency plus butterfly latency.
//  Sits between the polynomial-op top FSM (start/done) and the RAM / twiddle ROM / butterfly datapath.
// PARAMETERS
//  N       256            transform length, power of 2, >= 4
//  LOGN    $clog2(N)      number of stages
//  ADDR_W  $clog2(N)      coefficient / twiddle address width
//  RD_LAT  1              RAM + twiddle ROM read latency, cycles
//  BF_LAT  1              butterfly register stages (A_in/B_in -> A_out/B_out)
// PORTS
//  clk          in   1        clock
//  reset        in   1        synchronous, active-high reset
//  start        in   1        request transform; sampled only in IDLE
//  mode_in      in   1        0 = NTT, 1 = iNTT; latched with accepted start
//  busy         out  1        high from the cycle after start is accepted until done
//  done         out  1        1-cycle pulse; transform complete
//  intt_mode    out  1        latched mode; drives butterfly iNTT_mode
//  rd_en        out  1        RAM / ROM read strobe
//  rd_addr_a    out  ADDR_W   RAM port-A read address
//  rd_addr_b    out  ADDR_W   RAM port-B read address
//  tw_addr      out  ADDR_W   twiddle ROM address (fwd and inv ROMs share it)
//  wr_en        out  1        RAM write strobe for butterfly A_out/B_out
//  wr_addr_a    out  ADDR_W   write address for A_out
//  wr_addr_b    out  ADDR_W   write address for B_out
//  stage_idx    out  ADDR_W   current stage 0..LOGN-1 (debug)
//  cycle_count  out  32       busy-cycle counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0, including intt_mode, counters and delay lines.
//  Reset mid-transform: abort next edge, no further wr_en, no done pulse; RAM contents undefined.
//  FSM: IDLE -(start)-> ISSUE -(j==N/2-1)-> DRAIN -(PIPE cycles)-> ISSUE (s+1) or DONE (s==LOGN-1) -> IDLE.
//  start in any state other than IDLE is ignored (no queueing). mode_in is ignored except when start is accepted.
//  PIPE = RD_LAT + BF_LAT.
//  Stage s, butterfly j (0..N/2-1), one per cycle in ISSUE, rd_en=1:
//    h = N >> (s+1); o = j & (h-1); g = j >> (LOGN-1-s)
//    rd_addr_a = g*2h + o; rd_addr_b = rd_addr_a + h; tw_addr = o << s
//  Write-back: wr_en, wr_addr_a/b = rd_en, rd_addr_a/b delayed exactly PIPE cycles through a shift register.
//  DRAIN: rd_en=0 for PIPE cycles, so stage s+1 never reads an address stage s has not yet written (no RAW hazard).
//  Timing: start accepted at edge 0 -> first rd_en in cycle 1 -> done in cycle 1 + LOGN*(N/2+PIPE).
//    After done: busy=0 in the same cycle, IDLE next cycle. Back-to-back start in the cycle after done is accepted.
//  Counters: j wraps N/2-1 -> 0 at stage change; s is not incremented past LOGN-1.
//  Arithmetic: all address math mod 2^ADDR_W, no overflow by construction.
// CONFIGURATION
//  NTT_SCHED_PERF_EN defined:
//    cycle_count clears on accepted start and increments every cycle busy=1.
//    It holds after done until the next start, saturates at 2^32-1, and reset clears it.
//  NTT_SCHED_PERF_EN undefined: cycle_count tied to 0; no counter flops.
// STRUCTURE
//  ntt_pkg: sched_state_e {IDLE, ISSUE, DRAIN, DONE}, localparam PIPE helper, ADDR_W function.
//  Sub-module ntt_addr_gen: combinational (s, j) -> {addr_a, addr_b, tw_addr}.
//    Reused later by the bit-reversal unit.
//  Top holds the FSM, j/s counters, PIPE-deep write delay line and the optional perf counter.
// TESTING
//  N=8, start with mode_in=0 -> stage 0 pairs (0,4)(1,5)(2,6)(3,7), tw 0,1,2,3.
//    Stage 2 pairs (0,1)(2,3)(4,5)(6,7), tw 0 all. done at cycle 19.
//  Each rd_en at cycle t -> wr_en with identical addresses at t+2; rd_en=0 in both DRAIN cycles per stage.
//  Pulse start while busy, including with mode_in=1 -> ignored; intt_mode stays 0; done still at cycle 19.
//  Assert reset at cycle 10 -> next cycle all outputs 0, no done. Then start with mode_in=1 -> full run, intt_mode=1.
//  start held high continuously -> done at 19, new transform accepted at cycle 20, busy again at 21.
//  NTT_SCHED_PERF_EN, N=8 -> cycle_count=18 after done. Without the macro -> cycle_count always 0.
//  End-to-end with butterfly plus golden model: N=8, Q=17, random input -> NTT then iNTT (+N^-1 scale) returns input.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants and helpers for the NTT stage scheduler and its address generator.
package ntt_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    function automatic int unsigned pipe_depth(input int unsigned rd_lat,
                                               input int unsigned bf_lat);
        return rd_lat + bf_lat;
    endfunction

    function automatic int unsigned addr_width(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational butterfly address generator: (stage, butterfly) -> pair addresses and twiddle index.
module ntt_addr_gen
    import ntt_pkg::*;
#(
    parameter int unsigned N      = 256,
    parameter int unsigned LOGN   = addr_width(N),
    parameter int unsigned ADDR_W = addr_width(N)
) (
    input  logic [ADDR_W-1:0] i_stage,
    input  logic [ADDR_W-2:0] i_bfly,
    output logic [ADDR_W-1:0] o_addr_a_c,
    output logic [ADDR_W-1:0] o_addr_b_c,
    output logic [ADDR_W-1:0] o_tw_addr_c
);

    logic [ADDR_W-1:0] w_j;
    logic [ADDR_W-1:0] w_h;
    logic [ADDR_W-1:0] w_o;
    logic [ADDR_W-1:0] w_g;

    // h is the half-span, o the offset inside a group, g the group number
    always_comb begin
        w_j         = ADDR_W'(i_bfly);
        w_h         = ADDR_W'(N / 2) >> i_stage;
        w_o         = w_j & (w_h - ADDR_W'(1));
        w_g         = w_j >> (ADDR_W'(LOGN - 1) - i_stage);
        o_addr_a_c  = (w_g << (ADDR_W'(LOGN) - i_stage)) + w_o;
        o_addr_b_c  = o_addr_a_c + w_h;
        o_tw_addr_c = w_o << i_stage;
    end

endmodule

// File: rtl/ntt_stage_scheduler.sv
// In-place radix-2 NTT/iNTT sequencer driving RAM, twiddle ROM and a butterfly datapath.
// Optional busy-cycle counter enabled by defining NTT_SCHED_PERF_EN.
module ntt_stage_scheduler
    import ntt_pkg::*;
#(
    parameter int unsigned N      = 256,
    parameter int unsigned LOGN   = addr_width(N),
    parameter int unsigned ADDR_W = addr_width(N),
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned BF_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_mode_in,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_intt_mode,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr_a,
    output logic [ADDR_W-1:0] o_rd_addr_b,
    output logic [ADDR_W-1:0] o_tw_addr,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr_a,
    output logic [ADDR_W-1:0] o_wr_addr_b,
    output logic [ADDR_W-1:0] o_stage_idx,
    output logic [31:0]       o_cycle_count
);

    localparam int unsigned PIPE = pipe_depth(RD_LAT, BF_LAT);
    localparam int unsigned HALF = N / 2;
    localparam int unsigned J_W  = ADDR_W - 1;
    localparam int unsigned D_W  = (PIPE > 1) ? $clog2(PIPE) : 1;

    logic [1:0]        r_state, w_state_nxt;
    logic [J_W-1:0]    r_j, w_j_nxt;
    logic [ADDR_W-1:0] r_s, w_s_nxt;
    logic [D_W-1:0]    r_dcnt, w_dcnt_nxt;
    logic              r_intt, w_intt_nxt;

    logic [ADDR_W-1:0] w_addr_a, w_addr_b, w_tw_addr;
    logic              w_issue_nxt;

    logic              r_busy, r_done, r_rd_en;
    logic [ADDR_W-1:0] r_rd_addr_a, r_rd_addr_b, r_tw_addr;
    logic              r_wr_en_pipe   [PIPE];
    logic [ADDR_W-1:0] r_wr_addr_a_pipe [PIPE];
    logic [ADDR_W-1:0] r_wr_addr_b_pipe [PIPE];

    // Addresses are computed from next-state counters so the outputs can be registered
    ntt_addr_gen #(
        .N      (N),
        .LOGN   (LOGN),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .i_stage     (w_s_nxt),
        .i_bfly      (w_j_nxt),
        .o_addr_a_c  (w_addr_a),
        .o_addr_b_c  (w_addr_b),
        .o_tw_addr_c (w_tw_addr)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_j     <= '0;
            r_s     <= '0;
            r_dcnt  <= '0;
            r_intt  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_j     <= w_j_nxt;
            r_s     <= w_s_nxt;
            r_dcnt  <= w_dcnt_nxt;
            r_intt  <= w_intt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_j_nxt     = r_j;
        w_s_nxt     = r_s;
        w_dcnt_nxt  = r_dcnt;
        w_intt_nxt  = r_intt;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_ISSUE;
                    w_j_nxt     = '0;
                    w_s_nxt     = '0;
                    w_intt_nxt  = i_mode_in;
                end
            end
            S_ISSUE: begin
                if (r_j == J_W'(HALF - 1)) begin
                    w_state_nxt = S_DRAIN;
                    w_dcnt_nxt  = '0;
                end else begin
                    w_j_nxt = r_j + J_W'(1);
                end
            end
            S_DRAIN: begin
                // Wait until the last write of this stage has landed before reading the next
                if (r_dcnt == D_W'(PIPE - 1)) begin
                    w_j_nxt = '0;
                    if (r_s == ADDR_W'(LOGN - 1)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_ISSUE;
                        w_s_nxt     = r_s + ADDR_W'(1);
                    end
                end else begin
                    w_dcnt_nxt = r_dcnt + D_W'(1);
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_issue_nxt = (w_state_nxt == S_ISSUE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr_a <= '0;
            r_rd_addr_b <= '0;
            r_tw_addr   <= '0;
            for (int i = 0; i < int'(PIPE); i++) begin
                r_wr_en_pipe[i]     <= 1'b0;
                r_wr_addr_a_pipe[i] <= '0;
                r_wr_addr_b_pipe[i] <= '0;
            end
        end else begin
            r_busy      <= w_issue_nxt || (w_state_nxt == S_DRAIN);
            r_done      <= (w_state_nxt == S_DONE);
            r_rd_en     <= w_issue_nxt;
            r_rd_addr_a <= w_issue_nxt ? w_addr_a  : '0;
            r_rd_addr_b <= w_issue_nxt ? w_addr_b  : '0;
            r_tw_addr   <= w_issue_nxt ? w_tw_addr : '0;
            // Write-back delay line matches RAM read plus butterfly latency
            r_wr_en_pipe[0]     <= r_rd_en;
            r_wr_addr_a_pipe[0] <= r_rd_addr_a;
            r_wr_addr_b_pipe[0] <= r_rd_addr_b;
            for (int i = 1; i < int'(PIPE); i++) begin
                r_wr_en_pipe[i]     <= r_wr_en_pipe[i-1];
                r_wr_addr_a_pipe[i] <= r_wr_addr_a_pipe[i-1];
                r_wr_addr_b_pipe[i] <= r_wr_addr_b_pipe[i-1];
            end
        end
    end

`ifdef NTT_SCHED_PERF_EN
    logic [31:0] r_cycle_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cycle_count <= '0;
        end else if ((r_state == S_IDLE) && i_start) begin
            r_cycle_count <= '0;
        end else if (r_busy && (r_cycle_count != '1)) begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    assign o_cycle_count = r_cycle_count;
`else
    assign o_cycle_count = '0;
`endif

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_intt_mode = r_intt;
    assign o_rd_en     = r_rd_en;
    assign o_rd_addr_a = r_rd_addr_a;
    assign o_rd_addr_b = r_rd_addr_b;
    assign o_tw_addr   = r_tw_addr;
    assign o_wr_en     = r_wr_en_pipe[PIPE-1];
    assign o_wr_addr_a = r_wr_addr_a_pipe[PIPE-1];
    assign o_wr_addr_b = r_wr_addr_b_pipe[PIPE-1];
    assign o_stage_idx = r_s;

endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// Self-checking bench for ntt_stage_scheduler at N=8 with a schedule model built from group/offset loops.
module tb_ntt_stage_scheduler;

    localparam int N      = 8;
    localparam int LOGN   = 3;
    localparam int ADDR_W = 3;
    localparam int HALF   = N / 2;
    localparam int PIPE   = 2;
    localparam int SLOT   = HALF + PIPE;
    localparam int T      = LOGN * SLOT;

    logic              clk = 1'b0;
    logic              reset, start, mode_in;
    logic              busy, done, intt_mode, rd_en, wr_en;
    logic [ADDR_W-1:0] rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b, stage_idx;
    logic [31:0]       cycle_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int sch_a [LOGN][HALF];
    int sch_b [LOGN][HALF];
    int sch_t [LOGN][HALF];
    int lit_a [LOGN][HALF] = '{'{0, 1, 2, 3}, '{0, 1, 4, 5}, '{0, 2, 4, 6}};
    int lit_b [LOGN][HALF] = '{'{4, 5, 6, 7}, '{2, 3, 6, 7}, '{1, 3, 5, 7}};
    int lit_t [LOGN][HALF] = '{'{0, 1, 2, 3}, '{0, 2, 0, 2}, '{0, 0, 0, 0}};

    ntt_stage_scheduler #(.N(N), .RD_LAT(1), .BF_LAT(1)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_start       (start),
        .i_mode_in     (mode_in),
        .o_busy        (busy),
        .o_done        (done),
        .o_intt_mode   (intt_mode),
        .o_rd_en       (rd_en),
        .o_rd_addr_a   (rd_addr_a),
        .o_rd_addr_b   (rd_addr_b),
        .o_tw_addr     (tw_addr),
        .o_wr_en       (wr_en),
        .o_wr_addr_a   (wr_addr_a),
        .o_wr_addr_b   (wr_addr_b),
        .o_stage_idx   (stage_idx),
        .o_cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic bit rd_active(input int k);
        return (k >= 1) && (k <= T) && (((k - 1) % SLOT) < HALF);
    endfunction

    // Classic Cooley-Tukey loop nest: groups of span 2h, offset k inside the group
    initial begin
        for (int s = 0; s < LOGN; s++) begin
            int h, idx;
            h   = N / (2 ** (s + 1));
            idx = 0;
            for (int base = 0; base < N; base += 2 * h) begin
                for (int kk = 0; kk < h; kk++) begin
                    sch_a[s][idx] = base + kk;
                    sch_b[s][idx] = base + kk + h;
                    sch_t[s][idx] = kk * (N / (2 * h));
                    idx++;
                end
            end
        end
    end

    // Model: k is the cycle index since start acceptance (0 = idle); compare every cycle
    initial begin
        int  k, m_intt, m_cnt, s, r, kw;
        bit  sr, ss, sm;
        k = 0; m_intt = 0; m_cnt = 0;
        forever begin
            @(posedge clk);
            sr = reset; ss = start; sm = mode_in;
            if (sr) begin
                k = 0; m_intt = 0; m_cnt = 0;
            end else if (k == 0) begin
                if (ss) begin
                    k = 1; m_intt = int'(sm); m_cnt = 0;
                end
            end else begin
                if (k <= T) m_cnt++;
                k = (k == T + 1) ? 0 : k + 1;
            end
            @(negedge clk);
            chk("busy", 32'(busy), 32'((k >= 1) && (k <= T)));
            chk("done", 32'(done), 32'(k == T + 1));
            chk("intt_mode", 32'(intt_mode), 32'(m_intt));
            chk("rd_en", 32'(rd_en), 32'(rd_active(k)));
            chk("wr_en", 32'(wr_en), 32'(rd_active(k - PIPE)));
`ifdef NTT_SCHED_PERF_EN
            chk("cycle_count", cycle_count, 32'(m_cnt));
`else
            chk("cycle_count", cycle_count, 32'd0);
`endif
            if ((k >= 1) && (k <= T)) begin
                chk("stage_idx", 32'(stage_idx), 32'((k - 1) / SLOT));
            end
            if (rd_active(k)) begin
                s = (k - 1) / SLOT;
                r = (k - 1) % SLOT;
                chk("rd_addr_a", 32'(rd_addr_a), 32'(sch_a[s][r]));
                chk("rd_addr_b", 32'(rd_addr_b), 32'(sch_b[s][r]));
                chk("tw_addr", 32'(tw_addr), 32'(sch_t[s][r]));
                chk("lit_rd_a", 32'(rd_addr_a), 32'(lit_a[s][r]));
                chk("lit_rd_b", 32'(rd_addr_b), 32'(lit_b[s][r]));
                chk("lit_tw", 32'(tw_addr), 32'(lit_t[s][r]));
            end
            if (rd_active(k - PIPE)) begin
                kw = k - PIPE;
                s  = (kw - 1) / SLOT;
                r  = (kw - 1) % SLOT;
                chk("wr_addr_a", 32'(wr_addr_a), 32'(sch_a[s][r]));
                chk("wr_addr_b", 32'(wr_addr_b), 32'(sch_b[s][r]));
            end
        end
    end

    // Called at a negedge inside cycle 1 of a run (c0 = cyc there); returns at the done cycle
    task automatic wait_done(input int c0, input int exp_k, input string name);
        int got;
        got = -1;
        for (int i = 0; (i < 40) && (got < 0); i++) begin
            if (done) got = cyc - c0 + 1;
            else @(negedge clk);
        end
        chk(name, 32'(got), 32'(exp_k));
    endtask

    task automatic chk_perf(input string name);
`ifdef NTT_SCHED_PERF_EN
        chk(name, cycle_count, 32'd18);
`else
        chk(name, cycle_count, 32'd0);
`endif
    endtask

    initial begin
        int c0, ndone;
        reset = 1'b1; start = 1'b0; mode_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rd_addr_a", 32'(rd_addr_a), 32'd0);
        chk("rst_wr_addr_b", 32'(wr_addr_b), 32'd0);
        chk("rst_stage_idx", 32'(stage_idx), 32'd0);
        reset = 1'b0;

        // Run 1: NTT with start pulses (mode 1) during busy that must be ignored
        @(negedge clk); start = 1'b1; mode_in = 1'b0;
        @(negedge clk); c0 = cyc; start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; mode_in = 1'b1;
        @(negedge clk); start = 1'b0; mode_in = 1'b0;
        repeat (5) @(negedge clk);
        start = 1'b1; mode_in = 1'b1;
        @(negedge clk); start = 1'b0; mode_in = 1'b0;
        wait_done(c0, 19, "done_cycle_run1");
        chk("intt_run1", 32'(intt_mode), 32'd0);
        chk_perf("perf_run1");

        // Run 2: abort with reset in cycle 10
        @(negedge clk); start = 1'b1; mode_in = 1'b0;
        @(negedge clk); c0 = cyc; start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rd_en", 32'(rd_en), 32'd0);
        chk("abort_wr_en", 32'(wr_en), 32'd0);
        chk("abort_rd_addr_b", 32'(rd_addr_b), 32'd0);
        chk("abort_tw_addr", 32'(tw_addr), 32'd0);
        chk("abort_cycle_count", cycle_count, 32'd0);
        reset = 1'b0;
        ndone = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);

        // Run 3: iNTT after the abort
        start = 1'b1; mode_in = 1'b1;
        @(negedge clk); c0 = cyc; start = 1'b0; mode_in = 1'b0;
        wait_done(c0, 19, "done_cycle_intt");
        chk("intt_run3", 32'(intt_mode), 32'd1);
        chk_perf("perf_run3");

        // Run 4: start held high -> back-to-back transforms
        @(negedge clk); start = 1'b1; mode_in = 1'b0;
        @(negedge clk); c0 = cyc;
        wait_done(c0, 19, "done_cycle_held");
        @(negedge clk);
        chk("held_busy_c20", 32'(busy), 32'd0);
        @(negedge clk);
        chk("held_busy_c21", 32'(busy), 32'd1);
        start = 1'b0;
        c0 = cyc;
        wait_done(c0, 19, "done_cycle_held2");
        chk("intt_held2", 32'(intt_mode), 32'd0);
        chk_perf("perf_held2");

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
